// File: rtl/vram_port_arbiter.sv
// VRAM port arbiter: drawer owns the port in active video, processor
// gets single-cycle slots in blanking; read data steered by a pipeline tag.
module vram_port_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int GUARD  = 2,
  parameter int WAIT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              display_enabled,
  input  logic              blank_ending,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [WAIT_W-1:0] cpu_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    CPU
  } state_e;

  typedef enum logic [1:0] {
    TAG_DISP,
    TAG_CPU,
    TAG_NONE
  } tag_e;

  localparam logic [WAIT_W-1:0] WAIT_ONE =
    {{(WAIT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  tag_e              tag_q, tag_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              guard;
  logic              grant_ok;

  // GUARD of zero means the timing has no end-of-blanking window
  assign guard    = blank_ending & (GUARD != 0);
  assign grant_ok = cpu_req & ~display_enabled & ~guard;

  always_comb begin
    state_d = grant_ok ? CPU : IDLE;
    gnt_d   = grant_ok;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (grant_ok) begin
      we_d    = cpu_we;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end
    tag_d = TAG_DISP;
    if (state_q == CPU) begin
      tag_d = we_q ? TAG_NONE : TAG_CPU;
    end
  end

  always_comb begin
    if (!cpu_req || gnt_q) begin
      wait_d = '0;
    end else if (&wait_q) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + WAIT_ONE;
    end
  end

  // returning data follows the tag issued with its address
  always_comb begin
    ddata_d  = ddata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (tag_q)
      TAG_DISP: ddata_d = mem_rdata;
      TAG_CPU: begin
        rdata_d  = mem_rdata;
        rvalid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst_n) begin
      unique case (1'b1)
        state_q == CPU: begin
          mem_addr  = addr_q;
          mem_we    = we_q;
          mem_wdata = wdata_q;
        end
        default: mem_addr = disp_addr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tag_q    <= TAG_DISP;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_q   <= '0;
      ddata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      ddata_q  <= ddata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign disp_data  = ddata_q;
  assign cpu_gnt    = gnt_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_wait   = wait_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a registered-read VRAM model.
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        display_enabled;
  logic        blank_ending;
  logic [17:0] disp_addr;
  logic [7:0]  disp_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] cpu_wait;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  vram [0:262143];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  vram_port_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .display_enabled (display_enabled),
    .blank_ending    (blank_ending),
    .disp_addr       (disp_addr),
    .disp_data       (disp_data),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_gnt         (cpu_gnt),
    .cpu_rvalid      (cpu_rvalid),
    .cpu_rdata       (cpu_rdata),
    .cpu_wait        (cpu_wait),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " disp_data"}, disp_data, 0);
    chk({tag, " gnt"}, cpu_gnt, 0);
    chk({tag, " rvalid"}, cpu_rvalid, 0);
    chk({tag, " rdata"}, cpu_rdata, 0);
    chk({tag, " wait"}, cpu_wait, 0);
    chk({tag, " mem_we"}, mem_we, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    logic [7:0] exp8;
    logic [7:0] dd;
    logic       gnt_seen;

    for (int a = 0; a < 262144; a++) begin
      exp8 = a[7:0];
      vram[a] = exp8 ^ 8'h5A;
    end

    rst_n           = 1'b0;
    display_enabled = 1'b1;
    blank_ending    = 1'b0;
    disp_addr       = 18'd3;
    cpu_req         = 1'b0;
    cpu_we          = 1'b0;
    cpu_addr        = '0;
    cpu_wdata       = '0;
    #3;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // active video: drawer data lags its address by two edges
    for (int i = 0; i <= 10; i++) begin
      disp_addr = 18'(i);
      tick();
      if (i >= 1) begin
        exp8 = 8'(i - 1) ^ 8'h5A;
        chk("disp_data", disp_data, exp8);
        chk("no_gnt_video", cpu_gnt, 0);
      end
    end

    // write pending through active video, granted in blanking
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 18'h00100;
    cpu_wdata = 8'hC3;
    repeat (3) tick();
    chk("wait_count", cpu_wait, 3);
    chk("wr_no_gnt", cpu_gnt, 0);
    display_enabled = 1'b0;
    tick();
    chk("wr_gnt", cpu_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 18'h00100);
    chk("wr_mem_wdata", mem_wdata, 8'hC3);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    tick();
    chk("wr_gnt_end", cpu_gnt, 0);
    chk("wr_we_end", mem_we, 0);
    chk("wr_wait_clr", cpu_wait, 0);

    // read back the written byte
    cpu_req = 1'b1;
    tick();
    chk("rd_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick();
    chk("rd_rvalid_t1", cpu_rvalid, 0);
    tick();
    chk("rd_rvalid_t2", cpu_rvalid, 1);
    chk("rd_rdata", cpu_rdata, 8'hC3);
    tick();
    chk("rd_rvalid_t3", cpu_rvalid, 0);

    // four back-to-back reads
    cpu_req  = 1'b1;
    cpu_addr = 18'h00010;
    for (int j = 0; j <= 6; j++) begin
      tick();
      chk("b2b_gnt", cpu_gnt, (j < 4) ? 1 : 0);
      chk("b2b_rvalid", cpu_rvalid, (j >= 2 && j <= 5) ? 1 : 0);
      if (j < 4) chk("b2b_mem_addr", mem_addr, 18'h10 + 18'(j));
      if (j >= 2 && j <= 5) begin
        exp8 = 8'(8'h10 + j - 2) ^ 8'h5A;
        chk("b2b_rdata", cpu_rdata, exp8);
      end
      if (j < 3) cpu_addr = 18'h11 + 18'(j);
      if (j == 3) cpu_req = 1'b0;
    end

    // guard window, then grant on the last blanking cycle
    blank_ending = 1'b1;
    cpu_req      = 1'b1;
    cpu_addr     = 18'h00020;
    repeat (3) begin
      tick();
      chk("guard_no_gnt", cpu_gnt, 0);
    end
    blank_ending    = 1'b0;
    display_enabled = 1'b1;
    repeat (2) begin
      tick();
      chk("video_no_gnt", cpu_gnt, 0);
    end
    chk("guard_wait", cpu_wait, 5);
    display_enabled = 1'b0;
    tick();
    chk("late_gnt", cpu_gnt, 1);
    display_enabled = 1'b1;
    cpu_req         = 1'b0;
    tick();
    chk("late_rvalid_t1", cpu_rvalid, 0);
    dd = disp_data;
    tick();
    chk("late_rvalid", cpu_rvalid, 1);
    chk("late_rdata", cpu_rdata, 8'h7A);
    chk("late_disp_hold", disp_data, dd);

    // wait counter saturation under forced active video
    cpu_req  = 1'b1;
    gnt_seen = 1'b0;
    repeat (70000) begin
      tick();
      if (cpu_gnt) gnt_seen = 1'b1;
    end
    chk("wait_sat", cpu_wait, 16'hFFFF);
    chk("sat_no_gnt", gnt_seen, 0);
    cpu_req = 1'b0;
    tick();
    chk("abandon_wait", cpu_wait, 0);
    chk("abandon_gnt", cpu_gnt, 0);
    chk("abandon_we", mem_we, 0);

    // reset the cycle after a read grant
    display_enabled = 1'b0;
    disp_addr       = 18'd5;
    cpu_req         = 1'b1;
    cpu_addr        = 18'h00013;
    tick();
    chk("rst_rd_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_rvalid", cpu_rvalid, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
